// File: rtl/mul_pkg.sv
// mul_pkg: shared types for the iterative RV32M multiplier.
// Op codes, FSM states and the default operand width.
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add step, sum = acc + mcand * digit << (step*BPC).
// Ports: acc/mcand/digit/step in, sum out; purely combinational.
import mul_pkg::*;

module mul_step #(
  parameter int W   = XLEN,
  parameter int BPC = 1,
  parameter int CW  = 5
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   mcand,
  input  logic [BPC-1:0] digit,
  input  logic [CW-1:0]  step,
  output logic [2*W-1:0] sum
);

  logic [2*W-1:0] wide;

  always_comb begin
    wide = {{W{1'b0}}, mcand} << (BPC * int'(step));
    sum  = acc;
    for (int i = 0; i < BPC; i++) begin
      if (digit[i]) begin
        sum = sum + (wide << i);
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle MUL/MULH/MULHSU/MULHU, magnitude shift-add + sign fix.
// Ports: clk rst_n start abort op a b -> busy done result. Option: MUL_EARLY_EXIT_EN.
import mul_pkg::*;

module seq_multiplier #(
  parameter int XLEN           = mul_pkg::XLEN,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_e        state, state_n;
  mul_op_e           op_in, op_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_step, acc_fix;
  logic [XLEN-1:0]   mcand, mplier;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              neg, sa, sb;
  logic              last, zero_op;

  assign op_in = mul_op_e'(op);
  // a is signed for all but MULHU, b only for MULH
  assign sa    = (op_in != MULHU) & a[XLEN-1];
  assign sb    = (op_in == MULH) & b[XLEN-1];
  // 0x80000000 negates to itself, read as unsigned
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;
  assign last  = (cnt == CW'(N - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign zero_op = (a == '0) | (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign acc_fix = neg ? -acc : acc;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  mul_step #(
    .W   (XLEN),
    .BPC (BITS_PER_CYCLE),
    .CW  (CW)
  ) u_step (
    .acc   (acc),
    .mcand (mcand),
    .digit (mplier[BITS_PER_CYCLE-1:0]),
    .step  (cnt),
    .sum   (acc_step)
  );

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_n = zero_op ? DONE : CALC;
        CALC: if (last) state_n = FIX;
        FIX:  state_n = DONE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MUL;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (!abort) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= sa ^ sb;
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) result <= '0;
          end
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          result <= (op_q == MUL) ? acc_fix[XLEN-1:0]
                                  : acc_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench, random + directed ops vs 64-bit model.
// Driver pushes expected result/cycle; a negedge monitor pops on done.
import mul_pkg::*;

module tb_seq_multiplier;

  localparam int BPC = 1;
  localparam int N   = XLEN / BPC;
  localparam int LAT = N + 2;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = '0;

  seq_multiplier #(
    .XLEN           (32),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Full product by sign/zero extension to 64 bits
  function automatic logic [31:0] model(logic [1:0] o,
                                        logic [31:0] x,
                                        logic [31:0] y);
    logic [63:0] ea, eb, p;
    ea = (o != 2'd3 && x[31]) ? {32'hFFFF_FFFF, x} : {32'h0, x};
    eb = (o == 2'd1 && y[31]) ? {32'hFFFF_FFFF, y} : {32'h0, y};
    p  = ea * eb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat_of(logic [31:0] x, logic [31:0] y);
`ifdef MUL_EARLY_EXIT_EN
    if (x == 0 || y == 0) return 1;
`endif
    return LAT;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_single_pulse", prev_done, 0);
        if (q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("latency", cyc, e.due);
          last_res = e.res;
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.res = model(o, x, y);
    e.due = cyc + lat_of(x, y);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((busy || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, n >= 200, 0);
  endtask

  initial begin
    int n;
    logic [1:0]  o;
    logic [31:0] x, y;

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 32'd7, 32'hFFFF_FFFD);
    wait_idle("mul_neg");
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);
    wait_idle("mulh_min");
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("mulhu_max");
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("mulhsu_m1");
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("mul_m1");

    // start re-pulsed mid-CALC is dropped
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op = 2'd3;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle("restart_ignored");

    // start in the done cycle is dropped
    issue(2'd3, 32'hDEAD_BEEF, 32'h0000_0013);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", n >= 100, 0);
    start = 1'b1;
    a = 32'd4;
    b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy", busy, 0);
    wait_idle("start_at_done");

    // abort at CALC cycle 10
    issue(2'd0, 32'h0000_1111, 32'h0000_2222);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    q.delete(q.size() - 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result_kept", result, last_res);
    repeat (40) @(negedge clk);
    chk("abort_idle", busy, 0);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_over_start", busy, 0);
    repeat (3) @(negedge clk);

    // reset mid-CALC
    issue(2'd1, 32'hCAFE_0001, 32'h8765_4321);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    q.delete(q.size() - 1);
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'd0, 32'd3, 32'd5);
    wait_idle("mul_3x5");

    issue(2'd3, 32'd0, 32'h0000_1234);
    wait_idle("zero_op");

    for (int i = 0; i < 1200; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 15) == 0) x = '0;
      if ($urandom_range(0, 15) == 0) y = '0;
      if ($urandom_range(0, 15) == 0) x = 32'h8000_0000;
      issue(o, x, y);
      wait_idle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
